pixel_pair_reader: RTL and testbench

//  Read-side sequencer for the dual-port pixel memory in the draw path. Drives an

---
 rtl/pixel_pair_reader.sv | 111 +++++++++++
 tb/tb_pixel_pair_reader.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_pair_reader.sv
// Read-side sequencer for the dual-port pixel memory: fetches even/odd word
// pairs over a fixed window and serialises them as A-then-B pixels on valid/ready.
`timescale 1ns/1ps
module pixel_pair_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int START_ADDR = 9728,
  parameter int END_ADDR   = 9984,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_B    = ADDR_W'(END_ADDR - 1);
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT_A, SHIFT_B, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] buf_b;

  // pix_data doubles as the A half of the pair buffer; only B needs holding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_a    <= START_A;
      addr_b    <= START_A + 1'b1;
      rd_en     <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      buf_b     <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_a <= START_A;
            addr_b <= START_A + 1'b1;
            rd_en  <= 1'b1;
            busy   <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          rd_en    <= 1'b0;
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            pix_data  <= rd_data_a;
            buf_b     <= rd_data_b;
            pix_valid <= 1'b1;
            state     <= SHIFT_A;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        SHIFT_A: begin
          if (pix_ready) begin
            pix_data <= buf_b;
            pix_last <= (addr_b == LAST_B);
            state    <= SHIFT_B;
          end
        end
        SHIFT_B: begin
          // pix_last already encodes whether this pair closes the window.
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (pix_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr_a <= addr_a + ADDR_W'(2);
              addr_b <= addr_b + ADDR_W'(2);
              rd_en  <= 1'b1;
              state  <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_pair_reader.sv
// Bench for pixel_pair_reader: READ_LAT=1 and READ_LAT=3 instances run side by side
// against a pipelined ROM model and a window-level pixel/address reference.
`timescale 1ns/1ps
module tb_pixel_pair_reader;

  localparam int START = 9728;
  localparam int END   = 9984;
  localparam int NPIX  = END - START;
  localparam int NPAIR = NPIX / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, pix_ready;
  logic [13:0] addr_a [2];
  logic [13:0] addr_b [2];
  logic        rd_en [2];
  logic        pix_valid [2];
  logic        pix_last [2];
  logic        busy [2];
  logic        done [2];
  logic [7:0]  rd_data_a [2];
  logic [7:0]  rd_data_b [2];
  logic [7:0]  pix_data [2];

  pixel_pair_reader #(.ADDR_W(14), .DATA_W(8), .START_ADDR(START), .END_ADDR(END), .READ_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .start(start), .addr_a(addr_a[0]), .addr_b(addr_b[0]), .rd_en(rd_en[0]),
    .rd_data_a(rd_data_a[0]), .rd_data_b(rd_data_b[0]), .pix_valid(pix_valid[0]), .pix_ready(pix_ready),
    .pix_data(pix_data[0]), .pix_last(pix_last[0]), .busy(busy[0]), .done(done[0]));

  pixel_pair_reader #(.ADDR_W(14), .DATA_W(8), .START_ADDR(START), .END_ADDR(END), .READ_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .start(start), .addr_a(addr_a[1]), .addr_b(addr_b[1]), .rd_en(rd_en[1]),
    .rd_data_a(rd_data_a[1]), .rd_data_b(rd_data_b[1]), .pix_valid(pix_valid[1]), .pix_ready(pix_ready),
    .pix_data(pix_data[1]), .pix_last(pix_last[1]), .busy(busy[1]), .done(done[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] key;
  logic       ready_mode;
  logic [7:0] noise;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom(input logic [13:0] a);
    return a[7:0] ^ key;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Memory model: each port returns its word READ_LAT cycles after rd_en, junk otherwise.
  logic [7:0] pa [2][3];
  logic [7:0] pb [2][3];
  logic       pv [2][3];
  always @(posedge clk) begin
    noise <= 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      pa[i][0] <= rom(addr_a[i]);
      pb[i][0] <= rom(addr_b[i]);
      pv[i][0] <= rd_en[i];
      for (int k = 1; k < 3; k++) begin
        pa[i][k] <= pa[i][k-1];
        pb[i][k] <= pb[i][k-1];
        pv[i][k] <= pv[i][k-1];
      end
    end
  end
  assign rd_data_a[0] = (pv[0][0] === 1'b1) ? pa[0][0] : noise;
  assign rd_data_b[0] = (pv[0][0] === 1'b1) ? pb[0][0] : ~noise;
  assign rd_data_a[1] = (pv[1][2] === 1'b1) ? pa[1][2] : noise;
  assign rd_data_b[1] = (pv[1][2] === 1'b1) ? pb[1][2] : ~noise;

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = ready_mode ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Observation records, sampled on the falling edge.
  int         rd_q [2][$];
  logic [7:0] pix_q [2][$];
  int         last_q [2][$];
  int         done_cnt [2];
  int         done_cyc [2];
  int         first_valid [2];
  int         last_acc [2];
  int         proto_err [2];
  logic       prev_stall [2];
  logic       prev_done [2];
  logic [7:0] prev_data [2];
  logic       prev_last [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset === 1'b1) begin
        if (rd_en[i] === 1'b1) begin
          rd_q[i].push_back(int'(addr_a[i]));
          if (addr_b[i] !== addr_a[i] + 14'd1 || pix_valid[i] !== 1'b0) proto_err[i]++;
        end
        if ((rd_en[i] === 1'b1 || pix_valid[i] === 1'b1 || done[i] === 1'b1) && busy[i] !== 1'b1) proto_err[i]++;
        if (prev_stall[i] && (pix_valid[i] !== 1'b1 || pix_data[i] !== prev_data[i] || pix_last[i] !== prev_last[i]))
          proto_err[i]++;
        if (done[i] === 1'b1) begin
          if (prev_done[i]) proto_err[i]++;
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        if (pix_valid[i] === 1'b1 && first_valid[i] < 0) first_valid[i] = cyc;
        if (pix_valid[i] === 1'b1 && pix_ready === 1'b1) begin
          if (pix_last[i] === 1'b1) last_q[i].push_back(pix_q[i].size());
          pix_q[i].push_back(pix_data[i]);
          last_acc[i] = cyc;
        end
        prev_stall[i] = (pix_valid[i] === 1'b1) && (pix_ready !== 1'b1);
        prev_done[i]  = (done[i] === 1'b1);
        prev_data[i]  = pix_data[i];
        prev_last[i]  = pix_last[i];
      end else begin
        prev_stall[i] = 1'b0;
        prev_done[i]  = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      rd_q[i].delete();
      pix_q[i].delete();
      last_q[i].delete();
      done_cnt[i] = 0;
      done_cyc[i] = -1;
      first_valid[i] = -1;
      last_acc[i] = -1;
      proto_err[i] = 0;
    end
  endtask

  task automatic pulse_start(output int s_edge);
    start = 1'b1;
    @(posedge clk);
    #1;
    s_edge = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic timed_out);
    int n = 0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    timed_out = (n >= budget);
    tick(3);
  endtask

  function automatic int seq_bad(input int i);
    int bad = (pix_q[i].size() != NPIX) ? 1 : 0;
    for (int n = 0; n < pix_q[i].size(); n++)
      if (pix_q[i][n] !== rom(14'(START + n))) bad++;
    return bad;
  endfunction

  function automatic int rd_bad(input int i);
    int bad = (rd_q[i].size() != NPAIR) ? 1 : 0;
    for (int k = 0; k < rd_q[i].size(); k++)
      if (rd_q[i][k] != START + 2 * k) bad++;
    return bad;
  endfunction

  function automatic logic [40:0] out_vec(input int i);
    return {addr_a[i], addr_b[i], rd_en[i], pix_valid[i], pix_data[i], pix_last[i], busy[i], done[i]};
  endfunction

  localparam logic [40:0] RESET_VEC = {14'd9728, 14'd9729, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    int s;
    reset = 1'b0; start = 1'b0; key = 8'h00; ready_mode = 1'b0;
    clear_mon();
    tick(3);
    reset = 1'b1;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_vec(i) !== RESET_VEC) begin
        errors++; $display("FAIL reset_idle[%0d] got %h want %h", i, out_vec(i), RESET_VEC);
      end
    end
    pulse_start(s);
    tick(30);
    #3 reset = 1'b0;
    #0.5;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_vec(i) !== RESET_VEC) begin
        errors++; $display("FAIL reset_async[%0d] got %h want %h", i, out_vec(i), RESET_VEC);
      end
    end
    tick(2);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_full_pass();
    int s, l, per_pass;
    logic to;
    key = 8'h00; ready_mode = 1'b0;
    clear_mon();
    pulse_start(s);
    wait_done(3000, to);
    checks++;
    if (to) begin errors++; $display("FAIL full_timeout got timeout want done"); end
    for (int i = 0; i < 2; i++) begin
      l = lat_of(i);
      per_pass = NPAIR * (l + 3);
      checks++;
      if (seq_bad(i) != 0) begin
        errors++; $display("FAIL full_pixels[%0d] got %0d bad (n=%0d) want 0", i, seq_bad(i), pix_q[i].size());
      end
      checks++;
      if (rd_bad(i) != 0) begin
        errors++; $display("FAIL full_rd_addr[%0d] got %0d bad (n=%0d) want 0", i, rd_bad(i), rd_q[i].size());
      end
      checks++;
      if (last_q[i].size() != 1 || last_q[i][0] != NPIX - 1) begin
        errors++; $display("FAIL full_last[%0d] got count %0d want single at %0d", i, last_q[i].size(), NPIX - 1);
      end
      checks++;
      if (first_valid[i] - s + 1 != l + 2) begin
        errors++; $display("FAIL full_first_valid[%0d] got cycle %0d want %0d", i, first_valid[i] - s + 1, l + 2);
      end
      checks++;
      if (last_acc[i] - s + 1 != per_pass) begin
        errors++; $display("FAIL full_pass_len[%0d] got %0d want %0d", i, last_acc[i] - s + 1, per_pass);
      end
      checks++;
      if (done_cnt[i] != 1 || done_cyc[i] - s + 1 != per_pass + 1) begin
        errors++; $display("FAIL full_done[%0d] got n=%0d cyc=%0d want n=1 cyc=%0d", i, done_cnt[i], done_cyc[i] - s + 1, per_pass + 1);
      end
      checks++;
      if (addr_a[i] !== 14'(END - 2) || addr_b[i] !== 14'(END - 1) || busy[i] !== 1'b0) begin
        errors++; $display("FAIL full_hold[%0d] got a=%0d b=%0d busy=%b want a=%0d b=%0d busy=0", i, addr_a[i], addr_b[i], busy[i], END - 2, END - 1);
      end
      checks++;
      if (proto_err[i] != 0) begin
        errors++; $display("FAIL full_protocol[%0d] got %0d violations want 0", i, proto_err[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int s;
    logic to;
    key = 8'($urandom); ready_mode = 1'b1;
    clear_mon();
    pulse_start(s);
    wait_done(6000, to);
    ready_mode = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL bp_timeout got timeout want done"); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (seq_bad(i) != 0) begin
        errors++; $display("FAIL bp_pixels[%0d] got %0d bad want 0", i, seq_bad(i));
      end
      checks++;
      if (rd_bad(i) != 0 || proto_err[i] != 0) begin
        errors++; $display("FAIL bp_protocol[%0d] got rd_bad=%0d viol=%0d want 0/0", i, rd_bad(i), proto_err[i]);
      end
      checks++;
      if (last_q[i].size() != 1 || last_q[i][0] != NPIX - 1) begin
        errors++; $display("FAIL bp_last[%0d] got count %0d want 1", i, last_q[i].size());
      end
    end
  endtask

  task automatic test_back_to_back_start();
    int s;
    logic to;
    key = 8'($urandom); ready_mode = 1'b1;
    clear_mon();
    pulse_start(s);
    repeat (300) begin
      start = 1'($urandom % 4 == 0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_done(6000, to);
    ready_mode = 1'b0;
    tick(20);
    checks++;
    if (to) begin errors++; $display("FAIL ign_timeout got timeout want done"); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (done_cnt[i] != 1 || rd_q[i].size() != NPAIR || busy[i] !== 1'b0) begin
        errors++; $display("FAIL ign_single_pass[%0d] got done=%0d rd=%0d busy=%b want 1/%0d/0", i, done_cnt[i], rd_q[i].size(), busy[i], NPAIR);
      end
      checks++;
      if (seq_bad(i) != 0) begin
        errors++; $display("FAIL ign_pixels[%0d] got %0d bad want 0", i, seq_bad(i));
      end
    end
  endtask

  task automatic test_reset_restart();
    int s, n;
    logic to;
    key = 8'($urandom); ready_mode = 1'b0;
    clear_mon();
    pulse_start(s);
    n = 0;
    while (pix_q[0].size() < 40 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL rst_reach40 got %0d pixels want 40", pix_q[0].size()); end
    #3 reset = 1'b0;
    #0.5;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_vec(i) !== RESET_VEC) begin
        errors++; $display("FAIL rst_abort[%0d] got %h want %h", i, out_vec(i), RESET_VEC);
      end
    end
    tick(2);
    reset = 1'b1;
    tick(2);
    clear_mon();
    pulse_start(s);
    wait_done(3000, to);
    checks++;
    if (to) begin errors++; $display("FAIL rst_timeout got timeout want done"); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pix_q[i].size() == 0 || pix_q[i][0] !== rom(14'(START))) begin
        errors++; $display("FAIL rst_first_pixel[%0d] got %h want %h", i, (pix_q[i].size() != 0) ? pix_q[i][0] : 8'hxx, rom(14'(START)));
      end
      checks++;
      if (seq_bad(i) != 0 || rd_bad(i) != 0 || done_cnt[i] != 1) begin
        errors++; $display("FAIL rst_repass[%0d] got pix_bad=%0d rd_bad=%0d done=%0d want 0/0/1", i, seq_bad(i), rd_bad(i), done_cnt[i]);
      end
      checks++;
      if (first_valid[i] - s + 1 != lat_of(i) + 2) begin
        errors++; $display("FAIL rst_first_valid[%0d] got %0d want %0d", i, first_valid[i] - s + 1, lat_of(i) + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_backpressure();
    test_back_to_back_start();
    test_reset_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
